// File: rtl/core_sleep_unit.sv
// Sleep controller for a small core: gates the core clock after a run of idle cycles
// and restores it on a wake or fetch-enable request.
module core_sleep_unit #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk_ungated_i,
  input  logic resetn,
  input  logic scan_cg_en_i,
  input  logic fetch_enable_i,
  input  logic wake_from_sleep_i,
  input  logic new_ascii_instr_i,
  input  logic core_busy_i,
  output logic clk_gated_o,
  output logic core_sleep_o,
  output logic fetch_enable_o
);

  typedef enum logic {AWAKE = 1'b0, SLEEP = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IDLE_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             fetch_en_q;
  logic             clk_en;
  logic             clk_en_q;
  logic             active;
  logic             wake_req;

  assign wake_req = wake_from_sleep_i | fetch_enable_i;
  assign active   = core_busy_i | new_ascii_instr_i | wake_req;

  always_ff @(posedge clk_ungated_i or posedge resetn) begin
    if (resetn) begin
      state_q    <= AWAKE;
      idle_cnt_q <= '0;
      fetch_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      fetch_en_q <= fetch_enable_i;
    end
  end

  // Wake requests are part of 'active', so they always win over the expiry decision.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      AWAKE: begin
        if (active) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_LAST) begin
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_SAT) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      SLEEP: begin
        if (wake_req) begin
          state_d    = AWAKE;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = AWAKE;
        idle_cnt_d = '0;
      end
    endcase
  end

  assign clk_en = (state_q == AWAKE);

  // Enable only moves while the clock is low, so a high phase is never cut short.
  always_latch begin
    if (resetn) begin
      clk_en_q <= 1'b1;
    end else if (!clk_ungated_i) begin
      clk_en_q <= clk_en;
    end
  end

  assign clk_gated_o    = clk_ungated_i & (clk_en_q | scan_cg_en_i);
  assign core_sleep_o   = (state_q == SLEEP);
  assign fetch_enable_o = fetch_en_q & ~core_sleep_o;

endmodule

// File: tb/tb_core_sleep_unit.sv
// Directed bench for core_sleep_unit: idle entry, hold-off, wake, counter restart,
// scan override, fetch-enable and asynchronous reset.
module tb_core_sleep_unit;

  logic clk_ungated_i = 1'b0;
  logic resetn, scan_cg_en_i, fetch_enable_i, wake_from_sleep_i;
  logic new_ascii_instr_i, core_busy_i;
  logic clk_gated_o, core_sleep_o, fetch_enable_o;

  int checks   = 0;
  int failures = 0;

  core_sleep_unit #(.IDLE_CYCLES(4), .CNT_W(8)) dut (
    .clk_ungated_i    (clk_ungated_i),
    .resetn           (resetn),
    .scan_cg_en_i     (scan_cg_en_i),
    .fetch_enable_i   (fetch_enable_i),
    .wake_from_sleep_i(wake_from_sleep_i),
    .new_ascii_instr_i(new_ascii_instr_i),
    .core_busy_i      (core_busy_i),
    .clk_gated_o      (clk_gated_o),
    .core_sleep_o     (core_sleep_o),
    .fetch_enable_o   (fetch_enable_o)
  );

  always #5 clk_ungated_i = ~clk_ungated_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_ungated_i);
    #1;
  endtask

  // Check gated clock in the high phase just sampled, then in the following low phase.
  task automatic chk_pulse(input string tag, input logic exp_high);
    chk({tag, "_hi"}, clk_gated_o, exp_high);
    @(negedge clk_ungated_i);
    #1;
    chk({tag, "_lo"}, clk_gated_o, 1'b0);
  endtask

  initial begin
    resetn            = 1'b1;
    scan_cg_en_i      = 1'b0;
    fetch_enable_i    = 1'b0;
    wake_from_sleep_i = 1'b0;
    new_ascii_instr_i = 1'b0;
    core_busy_i       = 1'b0;

    // Reset held for 10 cycles, clock passes through
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_sleep", core_sleep_o, 1'b0);
      chk("rst_fetch", fetch_enable_o, 1'b0);
      chk_pulse("rst_gclk", 1'b1);
    end
    tick();
    resetn = 1'b0;

    // Idle entry: sleep on the 4th edge, first suppressed pulse on the 5th
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("idle_awake", core_sleep_o, 1'b0);
      chk_pulse("idle_gclk_on", 1'b1);
    end
    tick();
    chk("idle_sleep4", core_sleep_o, 1'b1);
    chk_pulse("idle_gclk_edge4_full", 1'b1);
    tick();
    chk_pulse("idle_gclk_edge5_off", 1'b0);
    tick();
    chk_pulse("idle_gclk_edge6_off", 1'b0);

    // Wake pulse for one cycle
    wake_from_sleep_i = 1'b1;
    tick();
    wake_from_sleep_i = 1'b0;
    chk("wake_awake", core_sleep_o, 1'b0);
    chk_pulse("wake_gclk_edgeN_off", 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("wake_resleep_wait", core_sleep_o, 1'b0);
      chk_pulse("wake_gclk_on", 1'b1);
    end
    tick();
    chk("wake_resleep4", core_sleep_o, 1'b1);

    // Busy hold-off: wake together with busy, keep busy 20 cycles
    wake_from_sleep_i = 1'b1;
    core_busy_i       = 1'b1;
    tick();
    wake_from_sleep_i = 1'b0;
    chk("busy_wake", core_sleep_o, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_hold", core_sleep_o, 1'b0);
    end
    core_busy_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("busy_drop_wait", core_sleep_o, 1'b0);
    end
    tick();
    chk("busy_drop_sleep4", core_sleep_o, 1'b1);

    // Busy is ignored while asleep
    core_busy_i       = 1'b1;
    new_ascii_instr_i = 1'b1;
    tick();
    chk("sleep_ignore_busy", core_sleep_o, 1'b1);
    core_busy_i       = 1'b0;
    new_ascii_instr_i = 1'b0;

    // Counter restart: 3 idle, instr pulse, then 4 more idle edges
    wake_from_sleep_i = 1'b1;
    tick();
    wake_from_sleep_i = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    chk("restart_idle3", core_sleep_o, 1'b0);
    new_ascii_instr_i = 1'b1;
    tick();
    new_ascii_instr_i = 1'b0;
    chk("restart_instr", core_sleep_o, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("restart_wait", core_sleep_o, 1'b0);
    end
    tick();
    chk("restart_sleep", core_sleep_o, 1'b1);

    // Wake on the expiry edge keeps the unit awake
    wake_from_sleep_i = 1'b1;
    tick();
    wake_from_sleep_i = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    wake_from_sleep_i = 1'b1;
    tick();
    wake_from_sleep_i = 1'b0;
    chk("expiry_wake_awake", core_sleep_o, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("expiry_wait", core_sleep_o, 1'b0);
    end
    tick();
    chk("expiry_sleep", core_sleep_o, 1'b1);
    tick();
    chk_pulse("expiry_gclk_off", 1'b0);

    // Scan override while asleep
    scan_cg_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("scan_sleep_held", core_sleep_o, 1'b1);
      chk_pulse("scan_gclk", 1'b1);
    end
    scan_cg_en_i = 1'b0;
    tick();
    chk_pulse("scan_off_gclk", 1'b0);
    chk("scan_fetch_off", fetch_enable_o, 1'b0);

    // Fetch-enable wakes and is forwarded
    fetch_enable_i = 1'b1;
    tick();
    chk("fetch_wake", core_sleep_o, 1'b0);
    chk("fetch_out", fetch_enable_o, 1'b1);
    tick();
    chk("fetch_out_hold", fetch_enable_o, 1'b1);
    chk_pulse("fetch_gclk_on", 1'b1);
    fetch_enable_i = 1'b0;
    tick();
    chk("fetch_out_drop", fetch_enable_o, 1'b0);
    for (int e = 1; e <= 3; e++) tick();
    chk("fetch_resleep", core_sleep_o, 1'b1);
    tick();
    chk_pulse("fetch_resleep_gclk_off", 1'b0);

    // Asynchronous reset mid-sleep, during a high phase
    @(posedge clk_ungated_i);
    #2;
    resetn = 1'b1;
    #1;
    chk("arst_sleep", core_sleep_o, 1'b0);
    chk("arst_fetch", fetch_enable_o, 1'b0);
    chk("arst_gclk", clk_gated_o, 1'b1);
    tick();
    chk_pulse("arst_gclk_next", 1'b1);
    tick();
    resetn = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    chk("arst_cnt_cleared", core_sleep_o, 1'b0);
    tick();
    chk("arst_resleep", core_sleep_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
